// File: rtl/uart_cmd_parser_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_parser_if
//
// Byte-in / command-out bundle between the UART receiver side and the
// command parser.
//
//   rx_valid   receiver -> parser  one-cycle strobe, rx_data holds a new byte
//   rx_data    receiver -> parser  received byte
//   cmd_valid  parser -> consumer  one-cycle pulse, a frame passed its checksum
//   cmd_addr   parser -> consumer  ADDR of the last good frame (held)
//   cmd_data   parser -> consumer  DATA of the last good frame (held)
//   chk_err    parser -> consumer  one-cycle pulse, checksum mismatch
//   tout_err   parser -> consumer  one-cycle pulse, inter-byte timeout
//   busy       parser -> consumer  high while a frame is being assembled
//
// master: the side that supplies bytes and watches results.
// slave : the parser itself.
// ---------------------------------------------------------------------------
interface uart_cmd_parser_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       cmd_valid;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       chk_err;
  logic       tout_err;
  logic       busy;

  modport master (
    output rx_valid,
    output rx_data,
    input  cmd_valid,
    input  cmd_addr,
    input  cmd_data,
    input  chk_err,
    input  tout_err,
    input  busy
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output cmd_valid,
    output cmd_addr,
    output cmd_data,
    output chk_err,
    output tout_err,
    output busy
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// uart_cmd_parser
//
// Assembles 4-byte command frames (SOF, ADDR, DATA, CHK) from the UART
// receiver byte stream. A frame whose CHK equals the 8-bit wrapping sum of
// ADDR and DATA produces a one-cycle cmd_valid with the command held on
// cmd_addr/cmd_data; a wrong CHK produces a one-cycle chk_err. If the line
// goes quiet for too long inside a frame, the frame is abandoned and a
// one-cycle tout_err is raised. All outputs are registered (latency 1).
//
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  uart_cmd_parser_if.slave (rx_valid/rx_data in; cmd_valid, cmd_addr,
//        cmd_data, chk_err, tout_err, busy out)
//
// Parameters:
//   SOF          start-of-frame byte value
//   TIMEOUT_CYC  idle cycles allowed between bytes inside a frame
//   CNT_W        timeout counter width, 2**CNT_W must exceed TIMEOUT_CYC
// ---------------------------------------------------------------------------
module uart_cmd_parser #(
  parameter logic [7:0]  SOF         = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 208320,
  parameter int unsigned CNT_W       = 18
) (
  input  logic              clk,
  input  logic              rst,
  uart_cmd_parser_if.slave  bus
);

  // Counter value at which a byte-less cycle becomes a timeout.
  localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StGetChk
  } state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_addr;
  logic [7:0]       r_data;
  logic             r_cmd_valid;
  logic [7:0]       r_cmd_addr;
  logic [7:0]       r_cmd_data;
  logic             r_chk_err;
  logic             r_tout_err;
  logic             r_busy;

  logic [7:0]       w_sum;
  logic             w_tout_hit;

  // 8-bit wrapping checksum of the captured payload.
  assign w_sum      = r_addr + r_data;
  assign w_tout_hit = (r_cnt == TOUT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_addr      <= 8'h00;
      r_data      <= 8'h00;
      r_cmd_valid <= 1'b0;
      r_cmd_addr  <= 8'h00;
      r_cmd_data  <= 8'h00;
      r_chk_err   <= 1'b0;
      r_tout_err  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // Pulses default low; each is set for a single cycle below.
      r_cmd_valid <= 1'b0;
      r_chk_err   <= 1'b0;
      r_tout_err  <= 1'b0;

      if (r_state == StIdle) begin
        r_cnt <= '0;
        if (bus.rx_valid && (bus.rx_data == SOF)) begin
          r_state <= StGetAddr;
          r_busy  <= 1'b1;
        end
      end else if (bus.rx_valid) begin
        // A byte always wins over a coincident timeout.
        r_cnt <= '0;
        case (r_state)
          StGetAddr: begin
            // Any value is accepted here, SOF included: no resync.
            r_addr  <= bus.rx_data;
            r_state <= StGetData;
          end
          StGetData: begin
            r_data  <= bus.rx_data;
            r_state <= StGetChk;
          end
          StGetChk: begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            if (bus.rx_data == w_sum) begin
              r_cmd_valid <= 1'b1;
              r_cmd_addr  <= r_addr;
              r_cmd_data  <= r_data;
            end else begin
              r_chk_err <= 1'b1;
            end
          end
          default: begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        endcase
      end else if (w_tout_hit) begin
        r_state    <= StIdle;
        r_cnt      <= '0;
        r_tout_err <= 1'b1;
        r_busy     <= 1'b0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.cmd_valid = r_cmd_valid;
  assign bus.cmd_addr  = r_cmd_addr;
  assign bus.cmd_data  = r_cmd_data;
  assign bus.chk_err   = r_chk_err;
  assign bus.tout_err  = r_tout_err;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_parser
//
// Two parser instances: dut_l with the default (long) timeout for the
// slow-baud good-frame scenario, dut_t with TIMEOUT_CYC=100 for everything
// else. For dut_t a frame-level reference model (byte queue plus timestamp
// arithmetic) runs on every negedge and emits expected events; the same
// block records the DUT's observed events. Each scenario task compares the
// two event lists and adds its own directed checks.
// ---------------------------------------------------------------------------
module tb_uart_cmd_parser;

  localparam int unsigned T    = 100;
  localparam int unsigned GAPL = 5208;
  localparam logic [7:0]  SOF  = 8'hA5;

  localparam logic [2:0] EV_CMD  = 3'd0;
  localparam logic [2:0] EV_CHK  = 3'd1;
  localparam logic [2:0] EV_TOUT = 3'd2;
  localparam logic [2:0] EV_BUSY = 3'd3;
  localparam logic [2:0] EV_OUT  = 3'd4;

  typedef struct packed {
    logic [31:0] n;
    logic [2:0]  kind;
    logic [7:0]  a;
    logic [7:0]  d;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_cmd_parser_if t_if ();
  uart_cmd_parser_if l_if ();

  uart_cmd_parser #(
    .SOF         (SOF),
    .TIMEOUT_CYC (T),
    .CNT_W       (7)
  ) dut_t (
    .clk (clk),
    .rst (rst),
    .bus (t_if)
  );

  uart_cmd_parser dut_l (
    .clk (clk),
    .rst (rst),
    .bus (l_if)
  );

  int n_checks = 0;
  int n_fails  = 0;

  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Byte seen by dut_t at the most recent edge.
  logic       pend_v = 1'b0;
  logic [7:0] pend_b = 8'h00;
  always @(posedge clk) begin
    pend_v <= t_if.rx_valid;
    pend_b <= t_if.rx_data;
  end

  ev_t         exp_q[$];
  ev_t         obs_q[$];
  logic [7:0]  m_frame[$];
  int unsigned m_last = 0;
  logic        m_busy = 1'b0;
  logic [7:0]  m_addr = 8'h00;
  logic [7:0]  m_data = 8'h00;
  logic [15:0] m_out  = 16'h0000;
  logic        o_busy = 1'b0;
  logic [15:0] o_out  = 16'h0000;
  int unsigned last_strobe = 0;

  function automatic ev_t mk_ev(input int unsigned n, input logic [2:0] k,
                                input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.n    = n;
    e.kind = k;
    e.a    = a;
    e.d    = d;
    return e;
  endfunction

  // Reference model and observer for dut_t. State after edge edge_n.
  always @(negedge clk) begin : model_mon
    logic [7:0] sum;
    if (rst) begin
      m_frame.delete();
      m_addr = 8'h00;
      m_data = 8'h00;
    end else begin
      if (pend_v) begin
        if (m_frame.size() != 0 || pend_b == SOF) m_frame.push_back(pend_b);
        m_last = edge_n;
        if (m_frame.size() == 4) begin
          sum = m_frame[1] + m_frame[2];
          if (m_frame[3] == sum) begin
            exp_q.push_back(mk_ev(edge_n, EV_CMD, m_frame[1], m_frame[2]));
            m_addr = m_frame[1];
            m_data = m_frame[2];
          end else begin
            exp_q.push_back(mk_ev(edge_n, EV_CHK, 8'h00, 8'h00));
          end
          m_frame.delete();
        end
      end
      if (m_frame.size() != 0 && edge_n - m_last == T) begin
        exp_q.push_back(mk_ev(edge_n, EV_TOUT, 8'h00, 8'h00));
        m_frame.delete();
      end
    end
    if ((m_frame.size() != 0) != m_busy) begin
      m_busy = ~m_busy;
      exp_q.push_back(mk_ev(edge_n, EV_BUSY, {7'd0, m_busy}, 8'h00));
    end
    if ({m_addr, m_data} != m_out) begin
      m_out = {m_addr, m_data};
      exp_q.push_back(mk_ev(edge_n, EV_OUT, m_addr, m_data));
    end

    if (t_if.cmd_valid !== 1'b0)
      obs_q.push_back(mk_ev(edge_n, EV_CMD, t_if.cmd_addr, t_if.cmd_data));
    if (t_if.chk_err !== 1'b0) obs_q.push_back(mk_ev(edge_n, EV_CHK, 8'h00, 8'h00));
    if (t_if.tout_err !== 1'b0) obs_q.push_back(mk_ev(edge_n, EV_TOUT, 8'h00, 8'h00));
    if (t_if.busy !== o_busy) begin
      o_busy = t_if.busy;
      obs_q.push_back(mk_ev(edge_n, EV_BUSY, {7'd0, t_if.busy}, 8'h00));
    end
    if ({t_if.cmd_addr, t_if.cmd_data} !== o_out) begin
      o_out = {t_if.cmd_addr, t_if.cmd_data};
      obs_q.push_back(mk_ev(edge_n, EV_OUT, t_if.cmd_addr, t_if.cmd_data));
    end
  end

  // Strobe one byte into dut_t, `gap` edges after the current one.
  task automatic send_t(input logic [7:0] b, input int unsigned gap);
    repeat (gap - 1) @(negedge clk);
    t_if.rx_valid = 1'b1;
    t_if.rx_data  = b;
    last_strobe   = edge_n + 1;
    @(negedge clk);
    t_if.rx_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (T + 10) @(negedge clk);
    #1;
  endtask

  function automatic int unsigned rand_gap();
    int unsigned r;
    r = $urandom_range(0, 15);
    if (r <= 5) return 1;
    if (r <= 9) return $urandom_range(2, 20);
    if (r == 10) return T - 1;
    if (r == 11) return T;
    if (r == 12) return T + 1;
    if (r == 13) return T + $urandom_range(2, 20);
    return $urandom_range(21, T - 2);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    t_if.rx_valid = 1'b0;
    t_if.rx_data  = 8'h00;
    l_if.rx_valid = 1'b0;
    l_if.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({t_if.cmd_valid, t_if.cmd_addr, t_if.cmd_data, t_if.chk_err, t_if.tout_err,
         t_if.busy} !== 20'h0) begin
      n_fails++;
      $display("FAIL reset_t: got v=%b a=%h d=%h c=%b t=%b b=%b, expected all 0",
               t_if.cmd_valid, t_if.cmd_addr, t_if.cmd_data, t_if.chk_err, t_if.tout_err,
               t_if.busy);
    end
    n_checks++;
    if ({l_if.cmd_valid, l_if.cmd_addr, l_if.cmd_data, l_if.chk_err, l_if.tout_err,
         l_if.busy} !== 20'h0) begin
      n_fails++;
      $display("FAIL reset_l: got v=%b a=%h d=%h c=%b t=%b b=%b, expected all 0",
               l_if.cmd_valid, l_if.cmd_addr, l_if.cmd_data, l_if.chk_err, l_if.tout_err,
               l_if.busy);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fails++;
      $display("FAIL reset_idle: got %0d events after release, expected 0", obs_q.size());
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_good_frame();
    logic [7:0]  bytes [4];
    int unsigned cmd_cnt = 0, cmd_at = 0, err_cnt = 0, busy_bad = 0;
    logic [7:0]  a_seen = 8'h00, d_seen = 8'h00;
    bytes[0] = 8'hA5;
    bytes[1] = 8'h12;
    bytes[2] = 8'h34;
    bytes[3] = 8'h46;
    // Iteration i observes state after relative edge i and drives edge i+1.
    for (int i = 0; i <= 3 * GAPL + 10; i++) begin
      @(negedge clk);
      if (l_if.cmd_valid === 1'b1) begin
        cmd_cnt++;
        cmd_at = i;
        a_seen = l_if.cmd_addr;
        d_seen = l_if.cmd_data;
      end
      if (l_if.chk_err !== 1'b0 || l_if.tout_err !== 1'b0) err_cnt++;
      if (l_if.busy !== (i >= 1 && i < 1 + 3 * GAPL)) busy_bad++;
      l_if.rx_valid = (i % GAPL == 0) && (i <= 3 * GAPL);
      l_if.rx_data  = (i <= 3 * GAPL) ? bytes[i / GAPL] : 8'h00;
    end
    l_if.rx_valid = 1'b0;
    n_checks++;
    if (cmd_cnt != 1) begin
      n_fails++;
      $display("FAIL good_frame cmd_count: got %0d, expected 1", cmd_cnt);
    end
    n_checks++;
    if (cmd_at != 1 + 3 * GAPL) begin
      n_fails++;
      $display("FAIL good_frame cmd_cycle: got %0d, expected %0d", cmd_at, 1 + 3 * GAPL);
    end
    n_checks++;
    if ({a_seen, d_seen} !== 16'h1234) begin
      n_fails++;
      $display("FAIL good_frame cmd: got %h/%h, expected 12/34", a_seen, d_seen);
    end
    n_checks++;
    if (err_cnt != 0) begin
      n_fails++;
      $display("FAIL good_frame err_pulses: got %0d, expected 0", err_cnt);
    end
    n_checks++;
    if (busy_bad != 0) begin
      n_fails++;
      $display("FAIL good_frame busy: got %0d wrong cycles, expected 0", busy_bad);
    end
    #1;
  endtask

  task automatic test_chk_wrap();
    int unsigned ncmd = 0, nchk = 0;
    send_t(8'hA5, 3);
    send_t(8'hF0, 5);
    send_t(8'h20, 5);
    send_t(8'h10, 5);
    send_t(8'hA5, 1);  // back-to-back SOF right after CHK
    send_t(8'h12, 4);
    send_t(8'h34, 4);
    send_t(8'h47, 4);
    drain();
    foreach (obs_q[i]) begin
      if (obs_q[i].kind == EV_CMD) ncmd++;
      if (obs_q[i].kind == EV_CHK) nchk++;
    end
    n_checks++;
    if (ncmd != 1 || nchk != 1) begin
      n_fails++;
      $display("FAIL chk_wrap pulses: got cmd=%0d chk=%0d, expected 1/1", ncmd, nchk);
    end
    n_checks++;
    if ({t_if.cmd_addr, t_if.cmd_data} !== 16'hF020) begin
      n_fails++;
      $display("FAIL chk_wrap hold: got %h/%h, expected F0/20", t_if.cmd_addr, t_if.cmd_data);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fails++;
      $display("FAIL chk_wrap events: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fails++;
        $display("FAIL chk_wrap ev%0d: got n=%0d k=%0d a=%h d=%h, expected n=%0d k=%0d a=%h d=%h",
                 i, obs_q[i].n, obs_q[i].kind, obs_q[i].a, obs_q[i].d,
                 exp_q[i].n, exp_q[i].kind, exp_q[i].a, exp_q[i].d);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_garbage_sof();
    int unsigned ncmd = 0, rise_at = 0, sof_at = 0;
    logic        rise_seen = 1'b0;
    send_t(8'h00, 3);
    send_t(8'hFF, 3);
    send_t(8'hA5, 3);
    sof_at = last_strobe;
    send_t(8'hA5, 3);
    send_t(8'hA5, 3);
    send_t(8'h4A, 3);
    drain();
    foreach (obs_q[i]) begin
      if (obs_q[i].kind == EV_CMD) ncmd++;
      if (obs_q[i].kind == EV_BUSY && !rise_seen) begin
        rise_seen = 1'b1;
        rise_at   = obs_q[i].n;
      end
    end
    n_checks++;
    if (ncmd != 1 || {t_if.cmd_addr, t_if.cmd_data} !== 16'hA5A5) begin
      n_fails++;
      $display("FAIL garbage cmd: got cnt=%0d %h/%h, expected 1 A5/A5", ncmd, t_if.cmd_addr,
               t_if.cmd_data);
    end
    n_checks++;
    if (rise_at != sof_at) begin
      n_fails++;
      $display("FAIL garbage busy_rise: got edge %0d, expected %0d", rise_at, sof_at);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fails++;
      $display("FAIL garbage events: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fails++;
        $display("FAIL garbage ev%0d: got n=%0d k=%0d a=%h d=%h, expected n=%0d k=%0d a=%h d=%h",
                 i, obs_q[i].n, obs_q[i].kind, obs_q[i].a, obs_q[i].d,
                 exp_q[i].n, exp_q[i].kind, exp_q[i].a, exp_q[i].d);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_timeout();
    int unsigned e12, ntout = 0, tout_at = 0, fall_at = 0;
    send_t(8'hA5, 2);
    send_t(8'h12, 4);
    e12 = last_strobe;
    drain();
    foreach (obs_q[i]) begin
      if (obs_q[i].kind == EV_TOUT) begin
        ntout++;
        tout_at = obs_q[i].n;
      end
      if (obs_q[i].kind == EV_BUSY && obs_q[i].a == 8'h00) fall_at = obs_q[i].n;
    end
    n_checks++;
    if (ntout != 1 || tout_at != e12 + T) begin
      n_fails++;
      $display("FAIL timeout tout: got cnt=%0d edge=%0d, expected 1 at %0d", ntout, tout_at,
               e12 + T);
    end
    n_checks++;
    if (fall_at != e12 + T) begin
      n_fails++;
      $display("FAIL timeout busy_fall: got edge %0d, expected %0d", fall_at, e12 + T);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fails++;
      $display("FAIL timeout events: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fails++;
        $display("FAIL timeout ev%0d: got n=%0d k=%0d a=%h d=%h, expected n=%0d k=%0d a=%h d=%h",
                 i, obs_q[i].n, obs_q[i].kind, obs_q[i].a, obs_q[i].d,
                 exp_q[i].n, exp_q[i].kind, exp_q[i].a, exp_q[i].d);
      end
    end
    obs_q.delete();
    exp_q.delete();
    send_t(8'hA5, 3);
    send_t(8'h01, 3);
    send_t(8'h02, 3);
    send_t(8'h03, 3);
    drain();
    n_checks++;
    if ({t_if.cmd_addr, t_if.cmd_data} !== 16'h0102 || obs_q.size() != exp_q.size()) begin
      n_fails++;
      $display("FAIL timeout recover: got %h/%h with %0d events, expected 01/02 with %0d",
               t_if.cmd_addr, t_if.cmd_data, obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fails++;
        $display("FAIL recover ev%0d: got n=%0d k=%0d a=%h d=%h, expected n=%0d k=%0d a=%h d=%h",
                 i, obs_q[i].n, obs_q[i].kind, obs_q[i].a, obs_q[i].d,
                 exp_q[i].n, exp_q[i].kind, exp_q[i].a, exp_q[i].d);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_timeout_boundary();
    int unsigned ntout = 0, ncmd = 0;
    // Each byte lands in the cycle the counter sits at T-1.
    send_t(8'hA5, 3);
    send_t(8'h12, T);
    send_t(8'h34, T);
    send_t(8'h46, T);
    drain();
    foreach (obs_q[i]) begin
      if (obs_q[i].kind == EV_TOUT) ntout++;
      if (obs_q[i].kind == EV_CMD) ncmd++;
    end
    n_checks++;
    if (ntout != 0 || ncmd != 1) begin
      n_fails++;
      $display("FAIL boundary pulses: got tout=%0d cmd=%0d, expected 0/1", ntout, ncmd);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fails++;
      $display("FAIL boundary events: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fails++;
        $display("FAIL boundary ev%0d: got n=%0d k=%0d a=%h d=%h, expected n=%0d k=%0d a=%h d=%h",
                 i, obs_q[i].n, obs_q[i].kind, obs_q[i].a, obs_q[i].d,
                 exp_q[i].n, exp_q[i].kind, exp_q[i].a, exp_q[i].d);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    int unsigned nerr = 0, ncmd = 0;
    send_t(8'hA5, 2);
    send_t(8'h12, 5);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({t_if.cmd_valid, t_if.cmd_addr, t_if.cmd_data, t_if.chk_err, t_if.tout_err,
         t_if.busy} !== 20'h0) begin
      n_fails++;
      $display("FAIL rst_mid async: got v=%b a=%h d=%h c=%b t=%b b=%b, expected all 0",
               t_if.cmd_valid, t_if.cmd_addr, t_if.cmd_data, t_if.chk_err, t_if.tout_err,
               t_if.busy);
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    drain();
    send_t(8'h34, 3);
    send_t(8'h46, 3);
    drain();
    foreach (obs_q[i]) if (obs_q[i].kind <= EV_TOUT) nerr++;
    n_checks++;
    if (nerr != 0) begin
      n_fails++;
      $display("FAIL rst_mid quiet: got %0d pulses, expected 0", nerr);
    end
    send_t(8'hA5, 3);
    send_t(8'h12, 3);
    send_t(8'h34, 3);
    send_t(8'h46, 3);
    drain();
    foreach (obs_q[i]) if (obs_q[i].kind == EV_CMD) ncmd++;
    n_checks++;
    if (ncmd != 1 || {t_if.cmd_addr, t_if.cmd_data} !== 16'h1234) begin
      n_fails++;
      $display("FAIL rst_mid cmd: got cnt=%0d %h/%h, expected 1 12/34", ncmd, t_if.cmd_addr,
               t_if.cmd_data);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fails++;
      $display("FAIL rst_mid events: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fails++;
        $display("FAIL rst_mid ev%0d: got n=%0d k=%0d a=%h d=%h, expected n=%0d k=%0d a=%h d=%h",
                 i, obs_q[i].n, obs_q[i].kind, obs_q[i].a, obs_q[i].d,
                 exp_q[i].n, exp_q[i].kind, exp_q[i].a, exp_q[i].d);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    logic [7:0]  a, d, c;
    int unsigned kind, nclash = 0;
    for (int f = 0; f < 40; f++) begin
      a    = 8'($urandom);
      d    = 8'($urandom);
      kind = $urandom_range(0, 9);
      c    = a + d;
      if (kind == 6 || kind == 7) c = c + 8'($urandom_range(1, 255));
      if (kind == 8) send_t(8'($urandom), rand_gap());
      send_t(SOF, rand_gap());
      send_t(a, rand_gap());
      if (kind != 9) begin
        send_t(d, rand_gap());
        send_t(c, rand_gap());
      end
    end
    drain();
    for (int i = 1; i < obs_q.size(); i++)
      if (obs_q[i].n == obs_q[i-1].n && obs_q[i].kind <= EV_TOUT && obs_q[i-1].kind <= EV_TOUT)
        nclash++;
    n_checks++;
    if (nclash != 0) begin
      n_fails++;
      $display("FAIL random exclusive: got %0d overlapping pulses, expected 0", nclash);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fails++;
      $display("FAIL random events: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fails++;
        $display("FAIL random ev%0d: got n=%0d k=%0d a=%h d=%h, expected n=%0d k=%0d a=%h d=%h",
                 i, obs_q[i].n, obs_q[i].kind, obs_q[i].a, obs_q[i].d,
                 exp_q[i].n, exp_q[i].kind, exp_q[i].a, exp_q[i].d);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_chk_wrap();
    test_garbage_sof();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
